// File: rtl/ctrl_state_machine_n.sv
// Flow-control supervisor for the PCIe transmit FIFO bank: INIT threshold latch,
// idle hold-off, error capture/clear. CTRL_SM_ERR_COUNT_EN adds an error-entry counter.
module ctrl_state_machine_n #(
    parameter int NUM_FIFOS = 5,
    parameter int UMBRAL_W  = 4,
    parameter int IDLE_HOLD = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          init,
    input  logic                          err_clr,
    input  logic [NUM_FIFOS*UMBRAL_W-1:0] umbrales_in,
    input  logic [NUM_FIFOS-1:0]          fifo_empty,
    input  logic [NUM_FIFOS-1:0]          fifo_error,
    output logic [3:0]                    state,
    output logic                          idle_out,
    output logic                          active_out,
    output logic                          error_out,
    output logic [NUM_FIFOS*UMBRAL_W-1:0] umbrales_out,
    output logic [NUM_FIFOS-1:0]          error_src
`ifdef CTRL_SM_ERR_COUNT_EN
    ,
    output logic [7:0]                    err_count
`endif
);

    localparam int CW = $clog2(IDLE_HOLD + 1);

    localparam logic [3:0] S_RESET  = 4'd0;
    localparam logic [3:0] S_INIT   = 4'd1;
    localparam logic [3:0] S_IDLE   = 4'd2;
    localparam logic [3:0] S_ACTIVE = 4'd4;
    localparam logic [3:0] S_ERROR  = 4'd8;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [CW-1:0] cnt_inc;
    logic [3:0]    nx;
    logic          idle_nx;
    logic          any_err;
    logic          all_empty;
    logic          hold_hit;

    assign any_err   = |fifo_error;
    assign all_empty = &fifo_empty;
    assign hold_hit  = (cnt == CW'(IDLE_HOLD));
    assign cnt_inc   = hold_hit ? cnt : cnt + CW'(1);

    // Counter defaults to zero so every state change clears it.
    always_comb begin
        nx      = state;
        cnt_nx  = '0;
        idle_nx = 1'b0;
        case (state)
            S_RESET: nx = S_INIT;
            S_INIT: begin
                if (init) nx = S_IDLE;
            end
            S_IDLE: begin
                if (any_err) begin
                    nx = S_ERROR;
                end else if (!all_empty) begin
                    nx = S_ACTIVE;
                end else begin
                    idle_nx = hold_hit;
                    cnt_nx  = cnt_inc;
                end
            end
            S_ACTIVE: begin
                if (any_err) begin
                    nx = S_ERROR;
                end else if (hold_hit) begin
                    nx = S_IDLE;
                end else begin
                    cnt_nx = all_empty ? cnt_inc : '0;
                end
            end
            S_ERROR: begin
                if (err_clr && !any_err) nx = S_IDLE;
            end
            default: nx = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_RESET;
            cnt          <= '0;
            idle_out     <= 1'b0;
            active_out   <= 1'b0;
            error_out    <= 1'b0;
            umbrales_out <= '0;
            error_src    <= '0;
        end else begin
            state      <= nx;
            cnt        <= cnt_nx;
            idle_out   <= idle_nx;
            active_out <= (nx == S_ACTIVE);
            error_out  <= (nx == S_ERROR);
            if (state == S_INIT && !init) umbrales_out <= umbrales_in;
            // Fresh capture on entry, accumulate while held, drop on exit.
            if (nx == S_ERROR)
                error_src <= ((state == S_ERROR) ? error_src : '0) | fifo_error;
            else
                error_src <= '0;
        end
    end

`ifdef CTRL_SM_ERR_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            err_count <= '0;
        else if (nx == S_ERROR && state != S_ERROR && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_ctrl_state_machine_n.sv
// Bench for ctrl_state_machine_n: directed test-plan steps, then random traffic
// compared against a mode/run-length reference model.
module tb_ctrl_state_machine_n;

    localparam int N  = 5;
    localparam int UW = 4;
    localparam int H  = 4;

    logic          clk = 1'b0;
    logic          reset, init, err_clr;
    logic [N*UW-1:0] umb_in;
    logic [N-1:0]  empty, ferr;
    logic [3:0]    state;
    logic          idle_out, active_out, error_out;
    logic [N*UW-1:0] umb_out;
    logic [N-1:0]  error_src;
`ifdef CTRL_SM_ERR_COUNT_EN
    logic [7:0]    err_count;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: mode 0..4 = reset/init/idle/active/error
    int            m_mode = 0;
    int            m_run = 0;
    logic          m_idle = 0, m_act = 0, m_err = 0;
    logic [N*UW-1:0] m_umb = '0;
    logic [N-1:0]  m_src = '0;
    int            m_ec = 0;

    ctrl_state_machine_n #(.NUM_FIFOS(N), .UMBRAL_W(UW), .IDLE_HOLD(H)) dut (
        .clk(clk),
        .reset(reset),
        .init(init),
        .err_clr(err_clr),
        .umbrales_in(umb_in),
        .fifo_empty(empty),
        .fifo_error(ferr),
        .state(state),
        .idle_out(idle_out),
        .active_out(active_out),
        .error_out(error_out),
        .umbrales_out(umb_out),
        .error_src(error_src)
`ifdef CTRL_SM_ERR_COUNT_EN
        ,
        .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] code(input int mode);
        return (mode == 0) ? 4'd0 : 4'(1 << (mode - 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task enter_err();
        m_mode = 4;
        m_src  = ferr;
        m_run  = 0;
        if (m_ec < 255) m_ec++;
    endtask

    task model();
        logic stay_idle;
        stay_idle = 1'b0;
        if (reset) begin
            m_mode = 0; m_run = 0; m_umb = '0; m_src = '0; m_ec = 0;
        end else begin
            case (m_mode)
                0: m_mode = 1;
                1: if (init) begin m_mode = 2; m_run = 0; end
                   else m_umb = umb_in;
                2: if (|ferr) enter_err();
                   else if (!(&empty)) begin m_mode = 3; m_run = 0; end
                   else begin stay_idle = (m_run >= H); m_run++; end
                3: if (|ferr) enter_err();
                   else if (m_run >= H) begin m_mode = 2; m_run = 0; end
                   else m_run = (&empty) ? m_run + 1 : 0;
                default: if (err_clr && ferr == '0) begin
                        m_mode = 2; m_src = '0; m_run = 0;
                    end else m_src = m_src | ferr;
            endcase
        end
        m_idle = stay_idle;
        m_act  = (m_mode == 3);
        m_err  = (m_mode == 4);
    endtask

    task step();
        @(posedge clk);
        model();
        #1;
        chk("state", 32'(state), 32'(code(m_mode)));
        chk("idle_out", 32'(idle_out), 32'(m_idle));
        chk("active_out", 32'(active_out), 32'(m_act));
        chk("error_out", 32'(error_out), 32'(m_err));
        chk("umbrales_out", 32'(umb_out), 32'(m_umb));
        chk("error_src", 32'(error_src), 32'(m_src));
`ifdef CTRL_SM_ERR_COUNT_EN
        chk("err_count", 32'(err_count), 32'(m_ec));
`endif
    endtask

    initial begin
        reset = 1; init = 0; err_clr = 0;
        umb_in = '0; empty = '1; ferr = '0;
        step(); step();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_flags", 32'({idle_out, active_out, error_out}), 32'd0);
        chk("rst_umb", 32'(umb_out), 32'd0);

        reset = 0; umb_in = 20'h4321F;
        step();
        chk("to_init", 32'(state), 32'd1);
        step(); step(); step();
        init = 1; umb_in = 20'hAAAAA;
        step();
        chk("to_idle", 32'(state), 32'd2);
        chk("umb_latched", 32'(umb_out), 32'h4321F);
        init = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("idle_early", 32'(idle_out), 32'd0);
        end
        step();
        chk("idle_hold", 32'(idle_out), 32'd1);
        chk("umb_frozen", 32'(umb_out), 32'h4321F);

        empty = 5'b11011;
        step();
        chk("go_active", 32'({state, active_out, idle_out}), 32'({4'd4, 1'b1, 1'b0}));
        empty = '1;
        step(); step(); step();
        empty = 5'b11110;
        step();
        empty = '1;
        step(); step(); step(); step();
        chk("active_hold", 32'(state), 32'd4);
        step();
        chk("back_idle", 32'({state, active_out}), 32'({4'd2, 1'b0}));

        empty = 5'b01111;
        step();
        chk("active_again", 32'(state), 32'd4);
        ferr = 5'b00010;
        step();
        ferr = 5'b10000;
        step();
        chk("err_state", 32'({state, error_out}), 32'({4'd8, 1'b1}));
        chk("err_src_or", 32'(error_src), 32'b10010);
        ferr = '0; err_clr = 1;
        step();
        chk("err_clear", 32'({state, error_out, error_src}), 32'({4'd2, 1'b0, 5'd0}));
        err_clr = 0;

        empty = 5'b01111; ferr = 5'b00001;
        step();
        chk("err_prio", 32'(state), 32'd8);
        ferr = '0;
        step();
        err_clr = 1; ferr = 5'b00100;
        step();
        chk("clr_vs_err", 32'({state, error_src}), 32'({4'd8, 5'b00101}));
        ferr = '0;
        step();
        err_clr = 0;
        step();
        chk("active_3", 32'(state), 32'd4);
        ferr = 5'b01000;
        step();
        ferr = '0;
        step();
`ifdef CTRL_SM_ERR_COUNT_EN
        chk("err_count3", 32'(err_count), 32'd3);
`endif
        err_clr = 1;
        step();
        err_clr = 0;
        step();
        chk("active_4", 32'(state), 32'd4);
        reset = 1;
        step();
        chk("midop_rst", 32'({state, idle_out, active_out, error_out, error_src}), 32'd0);
        chk("midop_umb", 32'(umb_out), 32'd0);
        reset = 0;

        for (int i = 0; i < 400; i++) begin
            reset   = ($urandom_range(99) == 0);
            init    = ($urandom_range(3) == 0);
            err_clr = ($urandom_range(4) == 0);
            empty   = ($urandom_range(2) != 0) ? '1 : 5'($urandom);
            ferr    = ($urandom_range(11) == 0) ? 5'(1 << $urandom_range(4)) : '0;
            umb_in  = 20'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctrl_state_machine_n.md
Name: ctrl_state_machine_n

Overview:
Parametrised flow-control state machine for the PCIe transmit-layer FIFO bank. It supervises NUM_FIFOS FIFOs (main, VCs, Ds) through a shared empty/error vector. It latches per-FIFO thresholds during INIT and reports IDLE/ACTIVE/ERROR status to the datapath. It adds hold-off idle detection, an ACTIVE->IDLE return path, sticky error-source capture and a software error clear.

Parameters:
NUM_FIFOS, 5, number of supervised FIFOs; bit i of every vector belongs to FIFO i.
UMBRAL_W, 4, width of one per-FIFO threshold.
IDLE_HOLD, 4, consecutive all-empty cycles required before idle is declared (>=1).

Ports:
clk  in  1  clock; all logic on posedge.
reset  in  1  synchronous reset, active-high.
init  in  1  ends INIT; thresholds are frozen.
err_clr  in  1  one-cycle pulse; leaves ERROR.
umbrales_in  in  NUM_FIFOS*UMBRAL_W  packed thresholds; FIFO i occupies bits [i*UMBRAL_W +: UMBRAL_W].
fifo_empty  in  NUM_FIFOS  per-FIFO empty flags.
fifo_error  in  NUM_FIFOS  per-FIFO overflow/underflow flags.
state  out  4  current state (registered).
idle_out  out  1  registered idle status.
active_out  out  1  registered active status.
error_out  out  1  registered error status.
umbrales_out  out  NUM_FIFOS*UMBRAL_W  latched thresholds.
error_src  out  NUM_FIFOS  sticky OR of fifo_error bits seen in ERROR.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high. All outputs are registered.
- State encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=4, ERROR=8. Any other value goes to RESET on the next cycle.
- reset=1 at a clock edge, in any state and mid-operation:
  - state=RESET.
  - idle_out, active_out, error_out = 0.
  - umbrales_out = 0, error_src = 0.
  - Idle counter is cleared.
- RESET: goes to INIT on the first edge with reset=0.
- INIT:
  - init=0: umbrales_out <= umbrales_in every cycle; stay in INIT.
  - init=1: go to IDLE. umbrales_out keeps its last value; the umbrales_in value present on the init edge is not captured.
  - From here on, umbrales_out holds until the next RESET.
- Idle counter:
  - Saturating counter, width $clog2(IDLE_HOLD+1).
  - Increments each cycle fifo_empty is all ones. Clears when any bit is 0.
  - Counts only in IDLE and ACTIVE; clears on entry to IDLE, ACTIVE and ERROR.
- IDLE:
  - Any fifo_error bit set -> ERROR. Error has priority over every other condition.
  - Else, any fifo_empty bit low -> ACTIVE; active_out=1 and idle_out=0 from the next cycle.
  - Else stay. idle_out is set on the cycle after the counter reaches IDLE_HOLD, which is IDLE_HOLD+1 edges after entry with all FIFOs empty.
- ACTIVE:
  - Any fifo_error bit set -> ERROR.
  - Else, counter reaches IDLE_HOLD -> IDLE; active_out=0 from the next cycle.
  - Else stay; active_out=1.
- ERROR:
  - On entry: error_out=1, active_out=0, idle_out=0, error_src <= fifo_error from the triggering cycle.
  - While in ERROR: error_src |= fifo_error each cycle.
  - err_clr=1 -> IDLE: error_out=0, error_src=0, counter cleared.
  - err_clr and a new fifo_error in the same cycle: stay in ERROR; the new bits are ORed in.
- init and err_clr are ignored in states where they are not listed.
- Latency: every output reflects the input condition exactly one edge later.

Optional Feature:
Macro CTRL_SM_ERR_COUNT_EN.
- Defined:
  - Adds output err_count (8 bits, reset 0).
  - Increments on each entry to ERROR; saturates at 255.
  - Cleared only by reset, not by err_clr.
- Undefined: the port and its counter do not exist; all other behaviour is identical.

Test Plan:
- Reset then INIT: reset=1 for 2 cycles, then 0; umbrales_in=0x4321F, init=0 for 3 cycles, then 1 -> state 0->1->2, umbrales_out=0x4321F, and it stays so after umbrales_in changes.
- Idle hold-off (IDLE_HOLD=4): fifo_empty=5'b11111 in IDLE -> idle_out=1 exactly 5 edges after IDLE entry. fifo_empty[2]=0 -> next cycle state=4, active_out=1, idle_out=0.
- ACTIVE->IDLE return: in ACTIVE, all-empty for 3 cycles, 1 not-empty, then 4 all-empty -> state stays 4 until the 4th consecutive all-empty, then 2 one edge later.
- Error capture and clear: in ACTIVE, fifo_error=5'b00010, then 5'b10000 one cycle later -> state=8, error_out=1, error_src=5'b10010. err_clr pulse -> state=2, error_out=0, error_src=0.
- Simultaneous events: in IDLE, fifo_empty=5'b01111 with fifo_error=5'b00001 -> state=8, not 4. In ERROR, err_clr=1 with fifo_error=5'b00100 -> stays 8, error_src gains bit 2.
- Mid-operation reset with CTRL_SM_ERR_COUNT_EN defined: three error entries -> err_count=3. reset=1 in ACTIVE -> next edge state=0, all outputs 0, err_count=0.
